// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_e        : arbiter FSM state encoding (S_IDLE / S_ACK)
//   StarveLimitDefault : default number of cycles a debug request may lose to the CPU
//   RstEnable          : reset-asserted level of resetn (active-low, global)
package dmem_arbiter_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } arb_state_e;

  localparam int unsigned StarveLimitDefault = 4;

  localparam logic RstEnable = 1'b0;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of the single-ported data memory.
// The CPU MEM stage has default priority; the host debug port gets a bounded wait
// (STARVE_LIMIT lost cycles) before it is forced through, stalling the CPU for one cycle.
//
// Optional feature: define DMEM_ARB_LOCK_EN to add input dbg_lock, which gives debug
// absolute priority and holds cpu_stallreq = cpu_req while asserted.
//
// Ports:
//   clk, resetn                         : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata               : MEM stage access request
//   cpu_rdata                           : memory read data to MEM stage (combinational)
//   cpu_stallreq                        : stall request to CTRL (combinational)
//   dbg_req/we/addr/wdata               : debug request, held until dbg_ack
//   dbg_ack                             : one-cycle completion pulse (registered)
//   dbg_rdata                           : captured debug read data (registered)
//   dbg_lock                            : debug lock (only with DMEM_ARB_LOCK_EN)
//   mem_addr/we/wdata, mem_rdata        : DATAMEM port (asynchronous read)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stallreq,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              dbg_lock,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // A zero limit still needs a one-bit counter to keep widths legal.
  localparam int unsigned      CntW  = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  arb_state_e        state_q;
  logic [CntW-1:0]   wait_cnt_q;
  logic              dbg_ack_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic lock;
  logic dbg_gnt;
  logic cpu_gnt;

`ifdef DMEM_ARB_LOCK_EN
  assign lock = dbg_lock;
`else
  assign lock = 1'b0;
`endif

  // Grant is masked during reset so no debug access leaks onto the memory port.
  assign dbg_gnt = (resetn != RstEnable) & dbg_req & (state_q == S_IDLE) &
                   (lock | ~cpu_req | (wait_cnt_q == Limit));
  assign cpu_gnt = cpu_req & ~dbg_gnt;

  // Under lock the CPU is frozen every cycle, not only on grant cycles.
  assign cpu_stallreq = cpu_req & (dbg_gnt | lock);
  assign cpu_rdata    = mem_rdata;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_we    = dbg_we;
      mem_wdata = dbg_wdata;
    end else if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end
  end

  // FSM, starvation counter and registered debug outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RstEnable) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (dbg_gnt) begin
            state_q     <= S_ACK;
            dbg_rdata_q <= mem_rdata;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      dbg_ack_q <= dbg_gnt;

      if (!dbg_req || dbg_gnt) begin
        wait_cnt_q <= '0;
      end else if ((state_q == S_IDLE) && (wait_cnt_q != Limit)) begin
        wait_cnt_q <= wait_cnt_q + CntW'(1);
      end
    end
  end

  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed phases from the test plan followed by
// randomized CPU/host traffic, all checked against a cycle-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stallreq;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          lock = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stallreq(cpu_stallreq),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_ack     (dbg_ack),
    .dbg_rdata   (dbg_rdata),
`ifdef DMEM_ARB_LOCK_EN
    .dbg_lock    (lock),
`endif
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // DATAMEM stand-in: 64 words, asynchronous read, write at the rising edge.
  logic [DW-1:0] ram [64];
  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;

  // Reference model state.
  bit            m_ack;
  int            m_loss;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_mem [64];
  int            gnt_count = 0;

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'h1234_5678 ^ (i * 32'h9E37_79B1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already applied at the falling edge.
  task automatic cycle();
    bit            e_gnt, c_gnt, e_stall;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    bit            e_we;
    #1;
    if (!resetn) begin
      m_ack   = 0;
      m_loss  = 0;
      m_rdata = '0;
    end
    // Debug wins when eligible and either the CPU is absent, it has waited long enough,
    // or lock is on.
    e_gnt   = resetn && dbg_req && !m_ack && (lock || !cpu_req || m_loss >= int'(LIMIT));
    c_gnt   = cpu_req && !e_gnt;
    e_stall = cpu_req && (e_gnt || lock);
    e_addr  = '0;
    e_wdata = '0;
    e_we    = 0;
    if (e_gnt) begin
      e_addr = dbg_addr; e_wdata = dbg_wdata; e_we = dbg_we;
    end else if (c_gnt) begin
      e_addr = cpu_addr; e_wdata = cpu_wdata; e_we = cpu_we;
    end
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("cpu_stallreq", 32'(cpu_stallreq), 32'(e_stall));
    chk("dbg_ack", 32'(dbg_ack), 32'(m_ack));
    chk("dbg_rdata", dbg_rdata, m_rdata);
    if (c_gnt) chk("cpu_rdata", cpu_rdata, m_mem[cpu_addr[7:2]]);
    if (e_gnt) gnt_count++;
    @(posedge clk);
    if (e_gnt) begin
      m_rdata = m_mem[dbg_addr[7:2]];
      if (dbg_we) m_mem[dbg_addr[7:2]] = dbg_wdata;
    end else if (c_gnt && cpu_we) begin
      m_mem[cpu_addr[7:2]] = cpu_wdata;
    end
    if (resetn) begin
      if (!dbg_req || e_gnt) m_loss = 0;
      else if (!m_ack) m_loss++;
      m_ack = e_gnt;
    end
    @(negedge clk);
  endtask

  task automatic rand_cpu(input int req_pct, input bit allow_we);
    cpu_req   = ($urandom_range(0, 99) < req_pct);
    cpu_we    = allow_we ? 1'($urandom_range(0, 1)) : 1'b0;
    cpu_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
    cpu_wdata = $urandom;
  endtask

  task automatic rand_dbg();
    dbg_we    = 1'($urandom_range(0, 1));
    dbg_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
    dbg_wdata = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int g0;
    resetn    = 1'b0;
    cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req   = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      ram[i]   <= init_word(i);
      m_mem[i] = init_word(i);
    end
    @(negedge clk);
    cycle();
    // During reset the CPU is still served and debug is blocked.
    cpu_req = 1'b1; dbg_req = 1'b1; cpu_addr = 32'h8;
    cycle();
    cpu_req = 1'b0; dbg_req = 1'b0;
    resetn  = 1'b1;
    cycle();

    // Debug write then read with CPU idle.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'hDEAD_BEEF;
    cycle();
    dbg_req = 1'b0;
    chk("wr_ack_latency", 32'(dbg_ack), 32'd1);
    cycle();
    dbg_req = 1'b1; dbg_we = 1'b0;
    cycle();
    dbg_req = 1'b0;
    chk("rd_ack_latency", 32'(dbg_ack), 32'd1);
    chk("rd_data", dbg_rdata, 32'hDEAD_BEEF);
    cycle();

    // Starvation bound with the CPU requesting every cycle.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
    lat = 0;
    while (!dbg_ack && lat < 20) begin
      rand_cpu(100, 1'b0);
      cycle();
      lat++;
    end
    chk("starve_latency", 32'(lat), 32'(LIMIT + 1));
    dbg_req = 1'b0;
    rand_cpu(100, 1'b0);
    cycle();

    // Held request: one grant every other cycle.
    cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_addr = 32'h30;
    g0 = gnt_count;
    for (int i = 0; i < 8; i++) cycle();
    chk("held_grants", 32'(gnt_count - g0), 32'd4);
    dbg_req = 1'b0;
    cycle();

    // Withdrawal under CPU load, then the wait starts over from zero.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'h0BAD_F00D;
    g0 = gnt_count;
    for (int i = 0; i < 2; i++) begin rand_cpu(100, 1'b0); cycle(); end
    dbg_req = 1'b0;
    for (int i = 0; i < 2; i++) begin rand_cpu(100, 1'b0); cycle(); end
    chk("withdraw_no_grant", 32'(gnt_count - g0), 32'd0);
    dbg_req = 1'b1; dbg_we = 1'b0;
    lat = 0;
    while (!dbg_ack && lat < 20) begin
      rand_cpu(100, 1'b0);
      cycle();
      lat++;
    end
    chk("post_withdraw_latency", 32'(lat), 32'(LIMIT + 1));
    dbg_req = 1'b0;
    cycle();

    // Reset asserted in the ack cycle.
    cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
    cycle();
    dbg_req = 1'b0;
    resetn  = 1'b0;
    #1;
    chk("rst_ack", 32'(dbg_ack), 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    cycle();
    resetn  = 1'b1;
    dbg_req = 1'b1;
    cycle();
    dbg_req = 1'b0;
    chk("post_rst_ack", 32'(dbg_ack), 32'd1);
    chk("post_rst_rdata", dbg_rdata, 32'hDEAD_BEEF);
    cycle();

`ifdef DMEM_ARB_LOCK_EN
    // Lock: CPU frozen throughout, debug granted on the first eligible cycle.
    lock    = 1'b1;
    dbg_req = 1'b1; dbg_addr = 32'h50;
    g0 = gnt_count;
    rand_cpu(100, 1'b0);
    cycle();
    chk("lock_first_grant", 32'(gnt_count - g0), 32'd1);
    for (int i = 0; i < 5; i++) begin rand_cpu(100, 1'b0); cycle(); end
    dbg_req = 1'b0;
    for (int i = 0; i < 2; i++) begin rand_cpu(100, 1'b0); cycle(); end
    lock = 1'b0;
    cycle();
`endif

    // Random traffic; the host may withdraw, and may reissue in the ack cycle.
    for (int n = 0; n < 600; n++) begin
      rand_cpu(60, 1'b1);
      if (dbg_req && m_ack) begin
        if ($urandom_range(0, 1) == 0) rand_dbg();
        else dbg_req = 1'b0;
      end else if (dbg_req) begin
        if ($urandom_range(0, 29) == 0) dbg_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        dbg_req = 1'b1;
        rand_dbg();
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
